// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, NBITS_DATA data bits (LSB first), optional parity, 1 or 2 stop bits.
// Define UART_TX_FRAME_PARITY_EN to build the parity state; otherwise i_parity_mode is ignored.
module uart_tx_frame #(
    parameter int NBITS_DATA = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick_brg,
    input  logic                  i_tx_start,
    input  logic [NBITS_DATA-1:0] i_data,
    input  logic [1:0]            i_parity_mode,
    input  logic                  i_stop_2,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done,
    output logic [2:0]            o_state
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = (NBITS_DATA > 2) ? $clog2(NBITS_DATA) : 1;
    localparam logic [TW-1:0] TICK_LAST_1 = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST_2 = TW'(2 * OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [TW-1:0]           r_tick_cnt;
    logic [TW-1:0]           w_tick_cnt_next;
    logic [BW-1:0]           r_bit_cnt;
    logic [BW-1:0]           w_bit_cnt_next;
    logic [NBITS_DATA-1:0]   r_shift;
    logic [NBITS_DATA-1:0]   w_shift_next;
    logic                    r_stop_2;
    logic                    r_tx;
    logic                    r_done;
    logic                    w_tx_next;
    logic                    w_done_next;
    logic                    w_accept;
    logic                    w_bit_end;
    logic [TW-1:0]           w_tick_last;

`ifdef UART_TX_FRAME_PARITY_EN
    logic                    r_parity_en;
    logic                    r_parity_bit;
`else
    logic                    w_unused_parity_mode;
    assign w_unused_parity_mode = ^i_parity_mode;
`endif

    // A tick only counts once a non-IDLE state is registered, so a tick on the accept edge is dropped.
    assign w_accept    = (r_state == ST_IDLE) && i_tx_start;
    assign w_tick_last = ((r_state == ST_STOP) && r_stop_2) ? TICK_LAST_2 : TICK_LAST_1;
    assign w_bit_end   = (r_state != ST_IDLE) && i_tick_brg && (r_tick_cnt == w_tick_last);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == BIT_LAST)) begin
`ifdef UART_TX_FRAME_PARITY_EN
                    w_state_next = r_parity_en ? ST_PARITY : ST_STOP;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_FRAME_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Line value is computed from the next state so the registered o_tx switches on the same edge as the state.
    always_comb begin
        w_tx_next   = 1'b1;
        w_done_next = (r_state == ST_STOP) && (w_state_next == ST_IDLE);
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_FRAME_PARITY_EN
            ST_PARITY: w_tx_next = r_parity_bit;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        if (w_accept) begin
            w_tick_cnt_next = '0;
            w_bit_cnt_next  = '0;
            w_shift_next    = i_data;
        end else if ((r_state != ST_IDLE) && i_tick_brg) begin
            if (w_bit_end) begin
                w_tick_cnt_next = '0;
                if (r_state == ST_DATA) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + BW'(1);
                end
            end else begin
                w_tick_cnt_next = r_tick_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_stop_2   <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
            if (w_accept) begin
                r_stop_2 <= i_stop_2;
            end
        end
    end

`ifdef UART_TX_FRAME_PARITY_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_parity_en  <= 1'b0;
            r_parity_bit <= 1'b0;
        end else if (w_accept) begin
            r_parity_en  <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            r_parity_bit <= (i_parity_mode == 2'b10) ? ~(^i_data) : (^i_data);
        end
    end
`endif

    assign o_tx      = r_tx;
    assign o_tx_busy = (r_state != ST_IDLE);
    assign o_tx_done = r_done;
    assign o_state   = r_state;

endmodule
